scan_mux_hex: RTL and testbench
===============================

SCAN_MUX_HEX -- requirements
Module: scan_mux_hex

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter DATA_W, default 4: bits per channel; legal range 1..4 (one hex digit).
REQ-003 Parameter DWELL, default 50000000: clock cycles each channel is shown in scan mode; legal range 2..2^32-1.
REQ-004 Define SEL_W = max(1, clog2(NUM_CH)).
REQ-005 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 DATA_IN  in  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SEL  in  SEL_W  manual channel select.
REQ-009 MODE  in  1  0 = manual select, 1 = auto-scan.
REQ-010 HOLD  in  1  freeze displayed channel and value.
REQ-011 MUX_OUT  out  DATA_W  registered selected-channel data.
REQ-012 CH_IDX  out  SEL_W  index of the channel currently shown.
REQ-013 CH_CHG  out  1  one-cycle pulse when CH_IDX changes value.
REQ-014 SEL_ERR  out  1  high while manual SEL >= NUM_CH.
REQ-015 HEX0  out  7  active-low seven-segment code of MUX_OUT, bit 0 = segment a ... bit 6 = segment g.

Function
REQ-016 State machine has states MANUAL, SCAN, FROZEN, encoded in registers only.
REQ-017 Transition priority each cycle: RESET > HOLD > MODE.
REQ-018 Any state, HOLD=1 -> FROZEN; FROZEN, HOLD=0 -> SCAN if MODE=1, else MANUAL.
REQ-019 MANUAL, MODE=1 -> SCAN; SCAN, MODE=0 -> MANUAL.
REQ-020 MANUAL: CH_IDX <= SEL when SEL < NUM_CH; otherwise CH_IDX holds and SEL_ERR=1 (combinational from SEL, gated to MANUAL state).
REQ-021 SCAN: 32-bit dwell counter counts 0..DWELL-1; at DWELL-1 counter clears and CH_IDX increments.
REQ-022 CH_IDX wraps NUM_CH-1 -> 0; it never takes a value >= NUM_CH.
REQ-023 Entering SCAN (from MANUAL or FROZEN) clears the dwell counter; scanning starts from the current CH_IDX.
REQ-024 FROZEN: CH_IDX, MUX_OUT, HEX0, and the dwell counter all hold; DATA_IN changes are ignored.
REQ-025 MANUAL and SCAN: MUX_OUT <= DATA_IN channel CH_IDX each cycle, i.e. MUX_OUT reflects a new CH_IDX one cycle after CH_IDX updates (SEL to MUX_OUT latency 2 cycles).
REQ-026 HEX0 is registered from MUX_OUT zero-extended to 4 bits, adding one further cycle (SEL to HEX0 latency 3 cycles).
REQ-027 HEX0 encoding (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-028 CH_CHG=1 for exactly the cycle after a CH_IDX register update that changed its value; it is 0 otherwise, including on reset release.
REQ-029 MODE and SEL changing in the same cycle: MODE governs; SEL is sampled only in MANUAL.

Reset
REQ-030 RESET=1 at a clock edge forces state MANUAL, CH_IDX=0, dwell counter=0, MUX_OUT=0, CH_CHG=0, HEX0=1000000.
REQ-031 RESET overrides HOLD and MODE, including mid-dwell and in FROZEN; normal operation resumes on the first edge with RESET=0.

Verification
REQ-032 Reset then MODE=0, SEL=2, DATA_IN=16'h4321 -> CH_IDX=2 after 1 cycle, MUX_OUT=3 after 2 cycles, HEX0=0110000 after 3 cycles, CH_CHG pulses once.
REQ-033 DWELL=4, MODE=1, CH_IDX=3 -> CH_IDX reads 3,3,3,3,0,0,0,0,1 over successive cycles; CH_CHG pulses at each wrap/increment.
REQ-034 DWELL=4, scanning, HOLD=1 for 10 cycles while DATA_IN changes -> MUX_OUT, HEX0, and CH_IDX are unchanged; after HOLD=0 the next CH_IDX change occurs 4 cycles later.
REQ-035 NUM_CH=3, MODE=0, SEL=3 -> SEL_ERR=1, CH_IDX keeps its previous value, no CH_CHG pulse.
REQ-036 RESET=1 asserted mid-dwell with HOLD=1 and MODE=1 -> next cycle CH_IDX=0, MUX_OUT=0, HEX0=1000000, state MANUAL.
REQ-037 Sweep all 16 values on channel 0, MODE=0, SEL=0 -> HEX0 matches the REQ-027 table for each value.

Source files
------------

// File: rtl/scan_mux_hex.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux_hex
// Description : Channel multiplexer for a single seven-segment digit. Shows
//               one of NUM_CH packed channels, chosen manually by SEL or
//               auto-scanned with a fixed dwell time, with a freeze control.
//               MUX_OUT, CH_IDX, CH_CHG and HEX0 are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_hex #(
    parameter int          NUM_CH = 4,
    parameter int          DATA_W = 4,
    parameter int unsigned DWELL  = 50000000,
    parameter int          SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic [NUM_CH*DATA_W-1:0]   DATA_IN,
    input  logic [SEL_W-1:0]           SEL,
    input  logic                       MODE,
    input  logic                       HOLD,
    output logic [DATA_W-1:0]          MUX_OUT,
    output logic [SEL_W-1:0]           CH_IDX,
    output logic                       CH_CHG,
    output logic                       SEL_ERR,
    output logic [6:0]                 HEX0
);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [31:0]      c_dwell_last = DWELL - 32'd1;
    localparam logic [31:0]      c_num_ch     = 32'(NUM_CH);
    localparam logic [SEL_W-1:0] c_last_ch    = SEL_W'(NUM_CH - 1);
    localparam logic [6:0]       c_seg_zero   = 7'b1000000;

    state_t             r_state;
    logic [SEL_W-1:0]   r_ch_idx;
    logic [31:0]        r_cnt;
    logic [DATA_W-1:0]  r_mux;
    logic [6:0]         r_hex;
    logic               r_chg;

    state_t             w_state_nx;
    logic [SEL_W-1:0]   w_idx_nx;
    logic [31:0]        w_cnt_nx;
    logic               w_load_mux;
    logic [DATA_W-1:0]  w_chan;
    logic [3:0]         w_nib;
    logic [6:0]         w_hex;
    logic               w_sel_ok;

    // Manual select is only legal when it names an existing channel
    assign w_sel_ok = ({{(32-SEL_W){1'b0}}, SEL} < c_num_ch);

    // Pick the data of the channel currently indexed
    always_comb begin
        w_chan = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch_idx == SEL_W'(k)) begin
                w_chan = DATA_IN[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next state, channel index and dwell count; HOLD outranks MODE
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_ch_idx;
        w_cnt_nx   = r_cnt;
        w_load_mux = 1'b0;
        if (HOLD) begin
            w_state_nx = ST_FROZEN;
        end else begin
            case (r_state)
                ST_FROZEN: begin
                    // Leaving freeze always restarts the dwell from zero
                    w_state_nx = MODE ? ST_SCAN : ST_MANUAL;
                    w_cnt_nx   = '0;
                end
                ST_MANUAL: begin
                    w_load_mux = 1'b1;
                    if (MODE) begin
                        w_state_nx = ST_SCAN;
                        w_cnt_nx   = '0;
                    end else if (w_sel_ok) begin
                        w_idx_nx = SEL;
                    end
                end
                ST_SCAN: begin
                    w_load_mux = 1'b1;
                    if (!MODE) begin
                        w_state_nx = ST_MANUAL;
                    end else if (r_cnt == c_dwell_last) begin
                        w_cnt_nx = '0;
                        w_idx_nx = (r_ch_idx == c_last_ch) ? '0 : r_ch_idx + SEL_W'(1);
                    end else begin
                        w_cnt_nx = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_MANUAL;
                end
            endcase
        end
    end

    // Active-low gfedcba decode of the displayed value
    assign w_nib = 4'(r_mux);
    always_comb begin
        case (w_nib)
            4'h0:    w_hex = 7'b1000000;
            4'h1:    w_hex = 7'b1111001;
            4'h2:    w_hex = 7'b0100100;
            4'h3:    w_hex = 7'b0110000;
            4'h4:    w_hex = 7'b0011001;
            4'h5:    w_hex = 7'b0010010;
            4'h6:    w_hex = 7'b0000010;
            4'h7:    w_hex = 7'b1111000;
            4'h8:    w_hex = 7'b0000000;
            4'h9:    w_hex = 7'b0010000;
            4'hA:    w_hex = 7'b0001000;
            4'hB:    w_hex = 7'b0000011;
            4'hC:    w_hex = 7'b1000110;
            4'hD:    w_hex = 7'b0100001;
            4'hE:    w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase
    end

    // State machine and registered outputs; HEX0 trails MUX_OUT by one cycle
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state  <= ST_MANUAL;
            r_ch_idx <= '0;
            r_cnt    <= '0;
            r_mux    <= '0;
            r_hex    <= c_seg_zero;
            r_chg    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ch_idx <= w_idx_nx;
            r_cnt    <= w_cnt_nx;
            if (w_load_mux) begin
                r_mux <= w_chan;
            end
            r_hex    <= w_hex;
            r_chg    <= (w_idx_nx != r_ch_idx);
        end
    end

    assign MUX_OUT = r_mux;
    assign CH_IDX  = r_ch_idx;
    assign CH_CHG  = r_chg;
    assign HEX0    = r_hex;
    assign SEL_ERR = (r_state == ST_MANUAL) && !w_sel_ok;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux_hex.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_mux_hex
// Description : Scoreboard bench for scan_mux_hex (3 channels, 4-bit data,
//               dwell of 4). A reference model predicts every post-edge
//               output and queues it; a monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux_hex;

    localparam int NCH = 3;
    localparam int DW  = 4;
    localparam int DWL = 4;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hold = 1'b0;
    logic              mode = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic [NCH*DW-1:0] din = '0;
    logic [DW-1:0]     mux_out;
    logic [SW-1:0]     ch_idx;
    logic              ch_chg;
    logic              sel_err;
    logic [6:0]        hex0;

    always #5 clk = ~clk;

    scan_mux_hex #(.NUM_CH(NCH), .DATA_W(DW), .DWELL(DWL)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .DATA_IN  (din),
        .SEL      (sel),
        .MODE     (mode),
        .HOLD     (hold),
        .MUX_OUT  (mux_out),
        .CH_IDX   (ch_idx),
        .CH_CHG   (ch_chg),
        .SEL_ERR  (sel_err),
        .HEX0     (hex0)
    );

    typedef struct packed {
        logic [3:0] mux;
        logic [1:0] idx;
        logic       chg;
        logic       err;
        logic [6:0] hex;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: frozen / scanning flags, dwell count, shown channel
    bit         m_frozen = 0;
    bit         m_scan   = 0;
    int         m_idx    = 0;
    int         m_cnt    = 0;
    int         m_mux    = 0;
    logic [6:0] m_hex    = 7'b1000000;
    bit         m_chg    = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic m,
                        input logic [SW-1:0] s, input logic [NCH*DW-1:0] d);
        int   prev_idx;
        int   prev_mux;
        exp_t e;
        @(negedge clk);
        rst = r; hold = h; mode = m; sel = s; din = d;
        prev_idx = m_idx;
        prev_mux = m_mux;
        if (r) begin
            m_frozen = 0; m_scan = 0; m_idx = 0; m_cnt = 0; m_mux = 0;
            m_hex = 7'b1000000;
        end else begin
            m_hex = seg[prev_mux];
            if (h) begin
                m_frozen = 1;
            end else if (m_frozen) begin
                m_frozen = 0;
                m_scan   = m;
                m_cnt    = 0;
            end else if (!m_scan) begin
                m_mux = int'((d >> (prev_idx*DW)) & 12'hF);
                if (m) begin
                    m_scan = 1;
                    m_cnt  = 0;
                end else if (int'(s) < NCH) begin
                    m_idx = int'(s);
                end
            end else begin
                m_mux = int'((d >> (prev_idx*DW)) & 12'hF);
                if (!m) begin
                    m_scan = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DWL) begin
                        m_cnt = 0;
                        m_idx = (m_idx + 1) % NCH;
                    end
                end
            end
        end
        m_chg = !r && (m_idx != prev_idx);
        e.mux = 4'(m_mux);
        e.idx = 2'(m_idx);
        e.chg = m_chg;
        e.err = !m_frozen && !m_scan && (int'(s) >= NCH);
        e.hex = m_hex;
        q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, compared shortly after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mux_out", int'(mux_out), int'(e.mux));
                chk("ch_idx",  int'(ch_idx),  int'(e.idx));
                chk("ch_chg",  int'(ch_chg),  int'(e.chg));
                chk("sel_err", int'(sel_err), int'(e.err));
                chk("hex0",    int'(hex0),    int'(e.hex));
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic
    initial begin
        logic [NCH*DW-1:0] d;
        logic r, h, m;
        logic [SW-1:0] s;
        d = 12'h321;
        repeat (2) step(1, 0, 0, 0, d);
        // manual select of channel 2, then an out-of-range select
        repeat (4) step(0, 0, 0, 2, d);
        repeat (3) step(0, 0, 0, 3, d);
        // every hex digit on channel 0
        for (int v = 0; v < 16; v++) begin
            repeat (3) step(0, 0, 0, 0, 12'(v));
        end
        // scanning from channel 2 with wrap
        repeat (3) step(0, 0, 0, 2, d);
        repeat (14) step(0, 0, 1, 2, d);
        // freeze while data changes, then resume scanning
        repeat (10) step(0, 1, 1, 0, 12'($urandom));
        repeat (8) step(0, 0, 1, 0, d);
        // reset mid-dwell overriding HOLD and MODE
        repeat (2) step(0, 0, 1, 0, d);
        step(1, 1, 1, 0, d);
        repeat (3) step(0, 0, 0, 1, d);
        // random traffic
        m = 1'b0;
        repeat (3000) begin
            r = ($urandom_range(0, 99) == 0);
            h = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) m = ~m;
            s = SW'($urandom_range(0, 3));
            d = 12'($urandom);
            step(r, h, m, s, d);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
